// File: rtl/scan_misr_state_bank.sv
// Scannable state-register bank with a windowed MISR that compacts primary outputs
// into a signature for golden-vs-suspect comparison.
module scan_misr_state_bank #(
    parameter int                   STATE_W     = 6,
    parameter int                   OUT_W       = 7,
    parameter logic [STATE_W-1:0]   RESET_STATE = '0,
    parameter logic [OUT_W-1:0]     MISR_POLY   = 7'h03,
    parameter int                   WINDOW      = 16,
    localparam int                  CW          = $clog2(WINDOW + 1)
) (
    input  logic               CK,
    input  logic               RST,
    input  logic [STATE_W-1:0] D,
    output logic [STATE_W-1:0] Q,
    input  logic               SE,
    input  logic               SI,
    output logic               SO,
    input  logic [OUT_W-1:0]   PO,
    input  logic               SIG_START,
    output logic [OUT_W-1:0]   SIG,
    output logic               SIG_VALID,
    output logic [CW-1:0]      CYC
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [OUT_W-1:0] misr_next;
    logic [CW-1:0]    cyc_inc;

    always_ff @(posedge CK) begin
        if (RST)
            Q <= RESET_STATE;
        else if (SE)
            Q <= {Q[STATE_W-2:0], SI};
        else
            Q <= D;
    end

    assign SO = Q[STATE_W-1];

    always_comb begin
        misr_next = {SIG[OUT_W-2:0], 1'b0} ^ (SIG[OUT_W-1] ? MISR_POLY : '0) ^ PO;
        cyc_inc   = CYC + CW'(1);
    end

    // Scan cycles (SE=1) never step the MISR, so the signature only sees functional cycles.
    always_ff @(posedge CK) begin
        if (RST) begin
            state     <= IDLE;
            SIG       <= '0;
            CYC       <= '0;
            SIG_VALID <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    SIG_VALID <= 1'b0;
                    if (SIG_START) begin
                        state <= RUN;
                        SIG   <= '0;
                        CYC   <= '0;
                    end
                end
                RUN: begin
                    if (SIG_START) begin
                        SIG <= '0;
                        CYC <= '0;
                    end else if (!SE) begin
                        SIG <= misr_next;
                        CYC <= cyc_inc;
                        if (cyc_inc == CW'(WINDOW)) begin
                            state     <= DONE;
                            SIG_VALID <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (SIG_START) begin
                        state     <= RUN;
                        SIG       <= '0;
                        CYC       <= '0;
                        SIG_VALID <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_misr_state_bank.sv
// Directed bench: two instances share stimulus; dut_a uses defaults (WINDOW=16),
// dut_b uses RESET_STATE=6'h15 and WINDOW=3.
module tb_scan_misr_state_bank;

    logic       CK = 1'b0;
    logic       RST, SE, SI, SIG_START;
    logic [5:0] D;
    logic [6:0] PO;

    logic [5:0] q_a, q_b;
    logic       so_a, so_b, val_a, val_b;
    logic [6:0] sig_a, sig_b;
    logic [4:0] cyc_a;
    logic [1:0] cyc_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 CK = ~CK;

    scan_misr_state_bank dut_a (
        .CK(CK), .RST(RST), .D(D), .Q(q_a), .SE(SE), .SI(SI), .SO(so_a),
        .PO(PO), .SIG_START(SIG_START), .SIG(sig_a), .SIG_VALID(val_a), .CYC(cyc_a)
    );

    scan_misr_state_bank #(.RESET_STATE(6'h15), .WINDOW(3)) dut_b (
        .CK(CK), .RST(RST), .D(D), .Q(q_b), .SE(SE), .SI(SI), .SO(so_b),
        .PO(PO), .SIG_START(SIG_START), .SIG(sig_b), .SIG_VALID(val_b), .CYC(cyc_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    initial begin
        logic [6:0] exp_sig;
        logic [5:0] si_seq;
        RST = 1'b1; SE = 1'b0; SI = 1'b0; D = '0; PO = '0; SIG_START = 1'b0;
        step();
        RST = 1'b0;

        // Reset after functional activity
        D = 6'h3F;
        repeat (3) step();
        chk("pre_rst_q", q_a, 6'h3F);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rst_q_a", q_a, 6'h00);
        chk("rst_q_b", q_b, 6'h15);
        chk("rst_sig", sig_a, 7'h00);
        chk("rst_cyc", cyc_a, 0);
        chk("rst_val_a", val_a, 0);
        chk("rst_val_b", val_b, 0);

        // Functional capture
        D = 6'h2A; step();
        chk("cap_q0", q_a, 6'h2A);
        chk("cap_so0", so_a, 1);
        D = 6'h15; step();
        chk("cap_q1", q_a, 6'h15);
        chk("cap_so1", so_a, 0);

        // Scan shift of 1,0,1,1,0,0
        RST = 1'b1; step(); RST = 1'b0;
        SE = 1'b1;
        si_seq = 6'b001101;
        for (int i = 0; i < 6; i++) begin
            SI = si_seq[i];
            step();
            chk($sformatf("scan_so%0d", i), so_a, (i == 5) ? 1 : 0);
            chk($sformatf("scan_sig%0d", i), sig_a, 7'h00);
        end
        chk("scan_q", q_a, 6'h2C);
        SE = 1'b0; SI = 1'b0;

        // MISR basic on the WINDOW=3 instance
        SIG_START = 1'b1; PO = '0; step(); SIG_START = 1'b0;
        chk("mb_start_sig", sig_b, 0);
        chk("mb_start_cyc", cyc_b, 0);
        PO = 7'h01;
        step(); chk("mb_sig1", sig_b, 7'h01); chk("mb_cyc1", cyc_b, 1); chk("mb_val1", val_b, 0);
        step(); chk("mb_sig2", sig_b, 7'h03); chk("mb_cyc2", cyc_b, 2); chk("mb_val2", val_b, 0);
        step(); chk("mb_sig3", sig_b, 7'h07); chk("mb_cyc3", cyc_b, 3); chk("mb_val3", val_b, 1);
        for (int i = 0; i < 10; i++) begin
            PO = 7'($urandom);
            SE = i[0];
            step();
            chk("mb_hold_sig", sig_b, 7'h07);
            chk("mb_hold_cyc", cyc_b, 3);
            chk("mb_hold_val", val_b, 1);
        end
        SE = 1'b0;

        // Feedback and scan freeze on the WINDOW=16 instance
        SIG_START = 1'b1; step(); SIG_START = 1'b0;
        PO = 7'h40; step();
        chk("fb_sig40", sig_a, 7'h40); chk("fb_cyc1", cyc_a, 1);
        SE = 1'b1;
        repeat (2) begin
            step();
            chk("fz_sig", sig_a, 7'h40);
            chk("fz_cyc", cyc_a, 1);
        end
        SE = 1'b0; PO = 7'h10; step();
        chk("fb_sig13", sig_a, 7'h13); chk("fb_cyc2", cyc_a, 2);

        // Restart mid-window
        PO = 7'h00; repeat (3) step();
        chk("rs_cyc5", cyc_a, 5);
        D = 6'h0F; SIG_START = 1'b1; step(); SIG_START = 1'b0;
        chk("rs_sig", sig_a, 0); chk("rs_cyc", cyc_a, 0); chk("rs_q", q_a, 6'h0F);
        PO = 7'h01;
        repeat (8) step();
        chk("rs_cyc8", cyc_a, 8);
        chk("rs_sig8", sig_a, 7'h7C);

        // Reset mid-window, then PO ignored in IDLE
        RST = 1'b1; step(); RST = 1'b0;
        chk("mr_sig", sig_a, 0); chk("mr_cyc", cyc_a, 0); chk("mr_val", val_a, 0);
        PO = 7'h55;
        repeat (3) begin
            step();
            chk("idle_sig", sig_a, 0);
            chk("idle_cyc", cyc_a, 0);
        end

        // Full 16-cycle window completes and holds
        SIG_START = 1'b1; step(); SIG_START = 1'b0;
        PO = 7'h01; exp_sig = '0;
        for (int i = 1; i <= 16; i++) begin
            exp_sig = {exp_sig[5:0], 1'b0} ^ (exp_sig[6] ? 7'h03 : 7'h00) ^ 7'h01;
            step();
            chk("win_cyc", cyc_a, i);
            chk("win_val", val_a, (i == 16) ? 1 : 0);
        end
        chk("win_sig", sig_a, exp_sig);
        PO = 7'h3A; SE = 1'b1; step(); SE = 1'b0; step();
        chk("win_hold_sig", sig_a, exp_sig);
        chk("win_hold_cyc", cyc_a, 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
